keypad_scanner: RTL and testbench

Matrix-keypad front end for the calculator datapath. Drives the columns of a 4x4 keypad, synchronizes and debounces the row returns, and encodes each debounced press into a 4-bit key code. Delivers one code per press over a valid/ready handshake to the number-input FSM directly downstream, which assembles codes into operands.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/keypad_decoder.sv | 35 +++
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: types and constants shared by the keypad front end and the
// number-input FSM. Holds the keypad FSM state set, the 4-bit key code type,
// the non-digit key codes and a row-priority helper.
package calc_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [2:0] {
        SCAN,
        PRESS_DB,
        EMIT,
        HELD,
        RELEASE_DB
    } kp_state_t;

    localparam key_code_t KEY_A    = 4'hA;
    localparam key_code_t KEY_B    = 4'hB;
    localparam key_code_t KEY_C    = 4'hC;
    localparam key_code_t KEY_D    = 4'hD;
    localparam key_code_t KEY_STAR = 4'hE;
    localparam key_code_t KEY_HASH = 4'hF;

    // Index of the lowest active-low row; row 0 wins when several are low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows_n[2]) idx = 2'd2;
        if (!rows_n[1]) idx = 2'd1;
        if (!rows_n[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// keypad_decoder: combinational (row, col) -> key code lookup for the 4x4
// calculator keypad. Digits encode as their value, letters as 0xA-0xD,
// '*' as 0xE and '#' as 0xF.
module keypad_decoder
    import calc_pkg::*;
(
    input  logic [1:0] i_row,
    input  logic [1:0] i_col,
    output key_code_t  o_code
);

    // Physical key layout to code translation.
    always_comb begin
        o_code = 4'h0;
        case ({i_row, i_col})
            4'b00_00: o_code = 4'h1;
            4'b00_01: o_code = 4'h2;
            4'b00_10: o_code = 4'h3;
            4'b00_11: o_code = KEY_A;
            4'b01_00: o_code = 4'h4;
            4'b01_01: o_code = 4'h5;
            4'b01_10: o_code = 4'h6;
            4'b01_11: o_code = KEY_B;
            4'b10_00: o_code = 4'h7;
            4'b10_01: o_code = 4'h8;
            4'b10_10: o_code = 4'h9;
            4'b10_11: o_code = KEY_C;
            4'b11_00: o_code = KEY_STAR;
            4'b11_01: o_code = 4'h0;
            4'b11_10: o_code = KEY_HASH;
            default:  o_code = KEY_D;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scanner, row synchronizer/debouncer and key encoder
// for the 4x4 calculator keypad. Emits one key code per debounced press over
// a valid/ready handshake and pulses key_overrun when a press is dropped
// because the previous code has not been consumed.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key every
// REPEAT_CYCLES cycles.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output key_code_t  key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_overrun
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]        r_rows_meta;
    logic [3:0]        r_rows_s;
    kp_state_t         r_state;
    logic [1:0]        r_col;
    logic [1:0]        r_row;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DB_W-1:0]   r_db_cnt;
    key_code_t         r_key_code;
    logic              r_key_valid;
    logic              r_overrun;

    key_code_t         w_code;
    logic              w_row_low;
    logic              w_any_low;
    logic [1:0]        w_first_row;
    logic              w_repeat;
    logic              w_emit;

    assign w_row_low   = ~r_rows_s[r_row];
    assign w_any_low   = ~&r_rows_s;
    assign w_first_row = lowest_low_row(r_rows_s);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] r_rep_cnt;
    assign w_repeat = (r_state == HELD) && w_row_low && (r_rep_cnt == REP_LAST);
`else
    assign w_repeat = 1'b0;
`endif

    // An emit happens on the single EMIT cycle or on an auto-repeat tick.
    assign w_emit = (r_state == EMIT) || w_repeat;

    assign cols        = ~(4'b0001 << r_col);
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_overrun = r_overrun;

    keypad_decoder u_decoder (
        .i_row  (r_row),
        .i_col  (r_col),
        .o_code (w_code)
    );

    // Two-flop synchronizer for the asynchronous row returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows_meta <= 4'hF;
            r_rows_s    <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_s    <= r_rows_meta;
        end
    end

    // Scan/debounce FSM together with the output handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_scan_cnt  <= '0;
            r_db_cnt    <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
`endif
        end else begin
            // A consumer handshake in the same cycle frees the slot for the new key.
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (r_key_valid && !key_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_key_code  <= w_code;
                    r_key_valid <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end

            case (r_state)
                SCAN: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (w_any_low) begin
                            r_row    <= w_first_row;
                            r_db_cnt <= '0;
                            r_state  <= PRESS_DB;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!w_row_low) begin
                        r_col   <= r_col + 2'd1;
                        r_state <= SCAN;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state <= EMIT;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    r_state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    r_rep_cnt <= '0;
`endif
                end
                HELD: begin
                    if (!w_row_low) begin
                        r_db_cnt <= '0;
                        r_state  <= RELEASE_DB;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (r_rep_cnt == REP_LAST) begin
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
`endif
                end
                RELEASE_DB: begin
                    if (w_row_low) begin
                        r_state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        r_rep_cnt <= '0;
`endif
                    end else if (r_db_cnt == DB_LAST) begin
                        r_col   <= r_col + 2'd1;
                        r_state <= SCAN;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a physical
// keypad model (pressed switch matrix shorting driven columns onto rows).
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int RP  = 50;
    localparam int LAT = 2 + 4 * SD + DB + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_overrun;

    logic [3:0][3:0] pressed;
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  acc_q[$];
    int          n_ovr;
    bit          rand_ready;
    bit          prev_hold;
    logic [3:0]  prev_code;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] exp;
    } vec_t;
    vec_t vt[16];

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rows        (rows),
        .cols        (cols),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_overrun (key_overrun)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
    end

    // Key code from the keypad legend: 3x3 digit block, letter column, bottom row.
    function automatic logic [3:0] ref_code(input int r, input int c);
        int v;
        if (c == 3)      v = 10 + r;
        else if (r < 3)  v = 3 * r + c + 1;
        else if (c == 0) v = 14;
        else if (c == 1) v = 0;
        else             v = 15;
        return 4'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock: observe at negedge, then advance to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        total++;
        if (!$onehot0(~cols)) begin
            bad++;
            $display("FAIL cols_onehot: cols=%b, expected at most one low", cols);
        end
        if (prev_hold && key_valid) begin
            total++;
            if (key_code !== prev_code) begin
                bad++;
                $display("FAIL code_stable: got %0h, expected %0h", key_code, prev_code);
            end
        end
        prev_hold = key_valid && !key_ready;
        prev_code = key_code;
        if (key_valid && key_ready) acc_q.push_back(key_code);
        if (key_overrun) n_ovr++;
        @(posedge clk);
        #1;
        if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int bound, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < bound) begin
            tick();
            n++;
            if (key_valid) ok = 1'b1;
        end
    endtask

    int  n_lat;
    bit  ok;
    int  cnt;
    logic [3:0] exp_q[$];

    initial begin
        pressed    = '0;
        key_ready  = 1'b0;
        rand_ready = 1'b0;
        prev_hold  = 1'b0;
        n_ovr      = 0;
        reset      = 1'b1;
        #2 reset   = 1'b0;
        #1;
        chk("rst_cols", cols, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_ovr", key_overrun, 1'b0);
        tick_n(3);
        reset = 1'b1;
        tick_n(5);

        // Every key of the pad once, ready high.
        vt = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
               '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
               '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
               '{3,0,4'hE}, '{3,1,4'h0}, '{3,2,4'hF}, '{3,3,4'hD}};
        key_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc_q.delete();
            pressed[vt[i].r][vt[i].c] = 1'b1;
            wait_valid(2 * LAT, n_lat, ok);
            chk($sformatf("tbl_valid_%0d", i), ok, 1'b1);
            chk($sformatf("tbl_code_%0d", i), key_code, vt[i].exp);
            tick_n(30);
            pressed = '0;
            tick_n(30);
            chk($sformatf("tbl_count_%0d", i), acc_q.size(), 1);
            if (acc_q.size() > 0) chk($sformatf("tbl_acc_%0d", i), acc_q[0], vt[i].exp);
        end

        // Single press of '6' held: one code within the latency bound, nothing more.
        acc_q.delete();
        pressed[1][2] = 1'b1;
        wait_valid(LAT, n_lat, ok);
        chk("press_latency_ok", ok, 1'b1);
        chk("press6_code", key_code, 4'h6);
        tick_n(60);
        chk("press6_held_count", acc_q.size(), 1);
        pressed = '0;
        tick_n(40);
        chk("press6_rel_count", acc_q.size(), 1);

        // Bouncy press and bouncy release of '8'.
        acc_q.delete();
        for (int i = 0; i < 20; i++) begin
            pressed[2][1] = (((i / 3) % 2) == 0);
            tick();
        end
        pressed[2][1] = 1'b1;
        tick_n(40);
        for (int i = 0; i < 20; i++) begin
            pressed[2][1] = (((i / 3) % 2) == 1);
            tick();
        end
        pressed = '0;
        tick_n(40);
        chk("bounce_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("bounce_code", acc_q[0], 4'h8);

        // Backpressure: 5 pending, 9 dropped with a single overrun pulse.
        acc_q.delete();
        n_ovr = 0;
        key_ready = 1'b0;
        pressed[1][1] = 1'b1; tick_n(40);
        pressed = '0;         tick_n(40);
        pressed[2][2] = 1'b1; tick_n(40);
        pressed = '0;         tick_n(40);
        chk("bp_valid", key_valid, 1'b1);
        chk("bp_code", key_code, 4'h5);
        chk("bp_overrun", n_ovr, 1);
        key_ready = 1'b1;
        tick();
        chk("bp_valid_cleared", key_valid, 1'b0);
        chk("bp_acc_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("bp_acc_code", acc_q[0], 4'h5);

        // Rows 0 and 2 together on column 0: row 0 wins.
        acc_q.delete();
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        wait_valid(2 * LAT, n_lat, ok);
        chk("multi_valid", ok, 1'b1);
        chk("multi_code", key_code, 4'h1);
        tick_n(30);
        pressed = '0;
        tick_n(40);
        chk("multi_count", acc_q.size(), 1);

        // Reset while debouncing a press on column 0.
        acc_q.delete();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pressed[0][0] = 1'b1;
        tick_n(7);
        reset = 1'b0;
        #1;
        chk("rstdb_cols", cols, 4'b1110);
        chk("rstdb_valid", key_valid, 1'b0);
        chk("rstdb_code", key_code, 4'h0);
        tick();
        chk("rstdb_cols_edge", cols, 4'b1110);
        chk("rstdb_valid_edge", key_valid, 1'b0);
        pressed = '0;
        reset = 1'b1;
        tick_n(40);
        chk("rstdb_no_key", acc_q.size(), 0);

        // Reset with a pending key: key is lost.
        key_ready = 1'b0;
        pressed[3][3] = 1'b1;
        wait_valid(2 * LAT, n_lat, ok);
        chk("rstkv_valid_before", ok, 1'b1);
        chk("rstkv_code_before", key_code, 4'hD);
        pressed = '0;
        tick_n(30);
        reset = 1'b0;
        prev_hold = 1'b0;
        #1;
        chk("rstkv_valid", key_valid, 1'b0);
        chk("rstkv_code", key_code, 4'h0);
        chk("rstkv_cols", cols, 4'b1110);
        chk("rstkv_ovr", key_overrun, 1'b0);
        tick();
        reset = 1'b1;
        tick_n(40);
        chk("rstkv_lost", key_valid, 1'b0);
        key_ready = 1'b1;

        // Hold '*' for 170 cycles past its first code.
        acc_q.delete();
        pressed[3][0] = 1'b1;
        wait_valid(2 * LAT, n_lat, ok);
        chk("star_valid", ok, 1'b1);
        tick_n(170);
        pressed = '0;
        tick_n(40);
        cnt = 0;
        foreach (acc_q[i]) if (acc_q[i] == 4'hE) cnt++;
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("star_repeat_count", cnt, 4);
`else
        chk("star_single_count", cnt, 1);
`endif
        chk("star_only_star", acc_q.size(), cnt);

        // Random single-key presses with random consumer readiness.
        acc_q.delete();
        exp_q.delete();
        n_ovr = 0;
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int r;
            int c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            exp_q.push_back(ref_code(r, c));
            pressed[r][c] = 1'b1;
            tick_n($urandom_range(40, 80));
            pressed = '0;
            tick_n($urandom_range(40, 80));
        end
        rand_ready = 1'b0;
        key_ready  = 1'b1;
        tick_n(10);
        chk("rand_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk($sformatf("rand_code_%0d", i), acc_q[i], exp_q[i]);
        chk("rand_no_overrun", n_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
